// File: rtl/switch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | switch_pkg: shared constants and helpers for the switch/LED channels |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package switch_pkg;

   localparam int   DEFAULT_DEBOUNCE_CYCLES = 250000;
   localparam logic MODE_TOGGLE             = 1'b0;
   localparam logic MODE_FOLLOW             = 1'b1;

   // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
   function automatic int cnt_width(input int cycles);
      return (cycles <= 2) ? 1 : $clog2(cycles);
   endfunction

endpackage : switch_pkg
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | switch_debounce: one channel's 2-flop synchroniser and debouncer     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module switch_debounce
   import switch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic i_Clk,
   input  logic i_Rst_L,
   input  logic i_Switch,
   output logic o_Stable,
   output logic o_Commit
);

   localparam int                 c_CNT_W = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

   logic               r_Sync1;
   logic               r_Sync2;
   logic               r_Stable;
   logic [c_CNT_W-1:0] r_Cnt;
   logic               w_Differ;
   logic               w_Commit;

   assign w_Differ = (r_Sync2 != r_Stable);
   assign w_Commit = w_Differ && (r_Cnt == c_LAST);

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_Sync1  <= 1'b0;
         r_Sync2  <= 1'b0;
         r_Stable <= 1'b0;
         r_Cnt    <= '0;
      end else begin
         r_Sync1 <= i_Switch;
         r_Sync2 <= r_Sync1;
         // Any sample matching the stable level restarts qualification.
         if (!w_Differ) begin
            r_Cnt <= '0;
         end else if (w_Commit) begin
            r_Stable <= r_Sync2;
            r_Cnt    <= '0;
         end else begin
            r_Cnt <= r_Cnt + c_ONE;
         end
      end
   end

   assign o_Stable = r_Stable;
   assign o_Commit = w_Commit;

endmodule : switch_debounce
`default_nettype wire

// File: rtl/switches_debounce_toggle_leds.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | switches_debounce_toggle_leds: multi-channel debounced LED toggler   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module switches_debounce_toggle_leds
   import switch_pkg::*;
#(
   parameter int NUM_CH            = 4,
   parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
   parameter bit TOGGLE_ON_RELEASE = 1'b1
) (
   input  logic              i_Clk,
   input  logic              i_Rst_L,
   input  logic [NUM_CH-1:0] i_Switch,
   input  logic [NUM_CH-1:0] i_Mode,
   input  logic              i_Clear,
   output logic [NUM_CH-1:0] o_LED,
   output logic [NUM_CH-1:0] o_Edge_Pulse,
   output logic [NUM_CH-1:0] o_Stable
);

   localparam logic c_ACTIVE_LVL = ~TOGGLE_ON_RELEASE;

   logic [NUM_CH-1:0] w_Stable;
   logic [NUM_CH-1:0] w_Commit;
   logic [NUM_CH-1:0] w_Follow;
   logic [NUM_CH-1:0] w_Active;
   logic [NUM_CH-1:0] w_Toggle_Next;
   logic [NUM_CH-1:0] w_LED_Next;
   logic [NUM_CH-1:0] r_Commit_D;
   logic [NUM_CH-1:0] r_LED;
   logic [NUM_CH-1:0] r_Edge_Pulse;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      switch_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .i_Clk   (i_Clk),
         .i_Rst_L (i_Rst_L),
         .i_Switch(i_Switch[g]),
         .o_Stable(w_Stable[g]),
         .o_Commit(w_Commit[g])
      );
      assign w_Follow[g] = (i_Mode[g] == MODE_FOLLOW);
   end

   // The commit strobe is delayed one cycle so the already-updated stable
   // level tells us which direction the committed edge went.
   assign w_Active      = r_Commit_D & (c_ACTIVE_LVL ? w_Stable : ~w_Stable);
   assign w_Toggle_Next = i_Clear ? '0 : (r_LED ^ w_Active);
   assign w_LED_Next    = (w_Follow & w_Stable) | (~w_Follow & w_Toggle_Next);

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_Commit_D   <= '0;
         r_LED        <= '0;
         r_Edge_Pulse <= '0;
      end else begin
         r_Commit_D   <= w_Commit;
         r_Edge_Pulse <= w_Active;
         r_LED        <= w_LED_Next;
      end
   end

   assign o_LED        = r_LED;
   assign o_Edge_Pulse = r_Edge_Pulse;
   assign o_Stable     = w_Stable;

endmodule : switches_debounce_toggle_leds
`default_nettype wire

// File: tb/tb_switches_debounce_toggle_leds.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_switches_debounce_toggle_leds: random stimulus vs reference model |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_switches_debounce_toggle_leds;

   localparam int NUM_CH = 4;
   localparam int DEB    = 4;
   localparam bit TOR    = 1'b1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NUM_CH-1:0] sw = '0;
   logic [NUM_CH-1:0] mode = '0;
   logic              clr = 1'b0;
   logic [NUM_CH-1:0] led, pulse, stable;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: switch samples seen at each clock edge, plus outputs.
   logic [NUM_CH-1:0] hist[$];
   logic [NUM_CH-1:0] m_stable, m_led, m_pulse, m_act;

   switches_debounce_toggle_leds #(
      .NUM_CH           (NUM_CH),
      .DEBOUNCE_CYCLES  (DEB),
      .TOGGLE_ON_RELEASE(TOR)
   ) dut (
      .i_Clk       (clk),
      .i_Rst_L     (rst_n),
      .i_Switch    (sw),
      .i_Mode      (mode),
      .i_Clear     (clr),
      .o_LED       (led),
      .o_Edge_Pulse(pulse),
      .o_Stable    (stable)
   );

   always #5 clk = ~clk;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < DEB + 2; i++) hist.push_back('0);
      m_stable = '0;
      m_led    = '0;
      m_pulse  = '0;
      m_act    = '0;
   endtask

   // A level commits once the DEB most recent synchronised samples (which
   // lag the raw input by two edges) all differ from the stable level.
   task automatic model_edge(input logic [NUM_CH-1:0] s, input logic [NUM_CH-1:0] m,
                             input logic c);
      int  last;
      bit  commit;
      m_pulse = m_act;
      for (int n = 0; n < NUM_CH; n++) begin
         if (m[n])          m_led[n] = m_stable[n];
         else if (c)        m_led[n] = 1'b0;
         else if (m_act[n]) m_led[n] = ~m_led[n];
      end
      hist.push_back(s);
      last = hist.size() - 1;
      for (int n = 0; n < NUM_CH; n++) begin
         commit = 1'b1;
         for (int j = last - DEB - 1; j <= last - 2; j++)
            if (hist[j][n] == m_stable[n]) commit = 1'b0;
         m_act[n] = 1'b0;
         if (commit) begin
            m_stable[n] = ~m_stable[n];
            m_act[n]    = (m_stable[n] == ~TOR);
         end
      end
      if (hist.size() > DEB + 2) void'(hist.pop_front());
   endtask

   task automatic step(input logic [NUM_CH-1:0] s, input logic [NUM_CH-1:0] m, input logic c);
      sw   = s;
      mode = m;
      clr  = c;
      @(posedge clk);
      model_edge(s, m, c);
      #1;
      chk_val("stable", 32'(stable), 32'(m_stable));
      chk_val("led",    32'(led),    32'(m_led));
      chk_val("pulse",  32'(pulse),  32'(m_pulse));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk_val("rst_stable", 32'(stable), 32'h0);
      chk_val("rst_led",    32'(led),    32'h0);
      chk_val("rst_pulse",  32'(pulse),  32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic repeat_step(input int k, input logic [NUM_CH-1:0] s,
                              input logic [NUM_CH-1:0] m, input logic c);
      for (int i = 0; i < k; i++) step(s, m, c);
   endtask

   initial begin
      logic [NUM_CH-1:0] rs, rm;
      logic              rc;
      model_reset();
      #2;
      sw = 4'hF;
      do_reset();
      // Held-pressed switches qualify from scratch after reset.
      repeat_step(8, 4'hF, 4'h0, 1'b0);
      repeat_step(8, 4'h0, 4'h0, 1'b0);
      // Mid-cycle reset during a partial count, then re-qualify.
      step(4'hF, 4'h0, 1'b0);
      step(4'hF, 4'h0, 1'b0);
      step(4'hF, 4'h0, 1'b0);
      do_reset();
      repeat_step(8, 4'hF, 4'h0, 1'b0);
      // Glitch rejection on ch1: 3-cycle pulse, then 4-cycle pulse.
      repeat_step(8, 4'h0, 4'h0, 1'b0);
      repeat_step(3, 4'h2, 4'h0, 1'b0);
      repeat_step(8, 4'h0, 4'h0, 1'b0);
      repeat_step(4, 4'h2, 4'h0, 1'b0);
      repeat_step(8, 4'h0, 4'h0, 1'b0);
      // Follow mode on ch2, then back to toggle.
      repeat_step(8, 4'h4, 4'h4, 1'b0);
      repeat_step(8, 4'h0, 4'h4, 1'b0);
      repeat_step(4, 4'h0, 4'h0, 1'b0);
      // Clear held across a release edge on all channels.
      repeat_step(8, 4'hF, 4'h0, 1'b0);
      repeat_step(8, 4'h0, 4'h0, 1'b1);
      // Random phase: rare switch flips, occasional mode changes and clears.
      rs = '0;
      rm = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int n = 0; n < NUM_CH; n++) begin
            if ($urandom_range(0, 9) == 0)  rs[n] = ~rs[n];
            if ($urandom_range(0, 59) == 0) rm[n] = ~rm[n];
         end
         rc = ($urandom_range(0, 15) == 0);
         step(rs, rm, rc);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_switches_debounce_toggle_leds
`default_nettype wire
